// File: rtl/traffic_light_ctrl_gen2.sv
`default_nettype none
// ============================================================================
// Module   : traffic_light_ctrl_gen2
// Purpose  : Highway / farm-road intersection controller. Moore FSM with a
//            single phase counter advanced by a tick strobe. It supports a
//            farm-road sensor, a latched pedestrian request and an emergency
//            override that clears the junction to all-red.
// Ports    : clk        - single clock, rising edge
//            reset      - asynchronous, active-low reset
//            tick_en    - time-base strobe, one tick per cycle when high
//            sensor     - farm-road vehicle present (level)
//            ped_req    - pedestrian request (pulse is enough, latched)
//            emergency  - emergency override (level)
//            light_HW   - highway lamp, one-hot {green, yellow, red}
//            light_FM   - farm lamp, same encoding
//            ped_walk   - walk indication, high only during farm green
//            state      - current state code (debug)
// Revision : 1.0 - initial release
// ============================================================================
module traffic_light_ctrl_gen2 #(
    parameter int YEL_TICKS        = 3,
    parameter int FM_GRN_TICKS     = 10,
    parameter int ALLRED_TICKS     = 1,
    parameter int MIN_HW_GRN_TICKS = 5,
    parameter int CNT_W            = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_en,
    input  logic       sensor,
    input  logic       ped_req,
    input  logic       emergency,
    output logic [2:0] light_HW,
    output logic [2:0] light_FM,
    output logic       ped_walk,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_HGRN  = 3'd0,
        ST_HYEL  = 3'd1,
        ST_AR1   = 3'd2,
        ST_FGRN  = 3'd3,
        ST_FYEL  = 3'd4,
        ST_AR2   = 3'd5,
        ST_EMERG = 3'd6,
        ST_ILL   = 3'd7
    } state_t;

    // Last counter value of each phase; the phase ends on the tick seen there.
    localparam logic [CNT_W-1:0] c_YEL_LAST    = CNT_W'(YEL_TICKS - 1);
    localparam logic [CNT_W-1:0] c_FM_GRN_LAST = CNT_W'(FM_GRN_TICKS - 1);
    localparam logic [CNT_W-1:0] c_ALLRED_LAST = CNT_W'(ALLRED_TICKS - 1);
    localparam logic [CNT_W-1:0] c_HW_MIN_LAST = CNT_W'(MIN_HW_GRN_TICKS - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE     = CNT_W'(1);

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_next_cnt;
    logic               r_ped_pending;
    logic               w_next_ped_pending;

    // ------------------------------------------------------------------------
    // State, counter and pedestrian-latch registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_HGRN;
            r_cnt         <= '0;
            r_ped_pending <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_cnt         <= w_next_cnt;
            r_ped_pending <= w_next_ped_pending;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // Emergency acts without a tick; everything else waits for tick_en.
    // Yellows always run to completion and only then divert to EMERG.
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_HGRN: begin
                if (emergency)
                    w_next_state = ST_HYEL;
                else if (tick_en && (r_cnt == c_HW_MIN_LAST) && (sensor || r_ped_pending))
                    w_next_state = ST_HYEL;
            end
            ST_HYEL: begin
                if (tick_en && (r_cnt == c_YEL_LAST))
                    w_next_state = emergency ? ST_EMERG : ST_AR1;
            end
            ST_AR1: begin
                if (emergency)
                    w_next_state = ST_EMERG;
                else if (tick_en && (r_cnt == c_ALLRED_LAST))
                    w_next_state = ST_FGRN;
            end
            ST_FGRN: begin
                if (emergency || (tick_en && (r_cnt == c_FM_GRN_LAST)))
                    w_next_state = ST_FYEL;
            end
            ST_FYEL: begin
                if (tick_en && (r_cnt == c_YEL_LAST))
                    w_next_state = emergency ? ST_EMERG : ST_AR2;
            end
            ST_AR2: begin
                if (emergency)
                    w_next_state = ST_EMERG;
                else if (tick_en && (r_cnt == c_ALLRED_LAST))
                    w_next_state = ST_HGRN;
            end
            ST_EMERG: begin
                // Recovery always passes through a full all-red clearance.
                if (!emergency)
                    w_next_state = ST_AR2;
            end
            ST_ILL: begin
                w_next_state = ST_HGRN;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Phase counter: cleared on any state change, parked at 0 in EMERG,
    // saturating in HGRN so the highway can hold green indefinitely.
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_cnt = r_cnt;
        if (w_next_state != r_state)
            w_next_cnt = '0;
        else if (r_state == ST_EMERG)
            w_next_cnt = '0;
        else if (tick_en) begin
            if ((r_state == ST_HGRN) && (r_cnt == c_HW_MIN_LAST))
                w_next_cnt = r_cnt;
            else
                w_next_cnt = r_cnt + c_CNT_ONE;
        end
    end

    // Pedestrian latch: served by the next farm green; clearing on FGRN
    // entry takes priority over a request arriving on the same edge.
    always_comb begin
        w_next_ped_pending = r_ped_pending;
        if ((w_next_state == ST_FGRN) && (r_state != ST_FGRN))
            w_next_ped_pending = 1'b0;
        else if (ped_req)
            w_next_ped_pending = 1'b1;
    end

    // ------------------------------------------------------------------------
    // Moore output decode; the illegal code shows highway green.
    // ------------------------------------------------------------------------
    always_comb begin
        light_HW = 3'b001;
        light_FM = 3'b001;
        ped_walk = 1'b0;
        case (r_state)
            ST_HGRN:  light_HW = 3'b100;
            ST_HYEL:  light_HW = 3'b010;
            ST_AR1:   light_HW = 3'b001;
            ST_FGRN: begin
                light_FM = 3'b100;
                ped_walk = 1'b1;
            end
            ST_FYEL:  light_FM = 3'b010;
            ST_AR2:   light_HW = 3'b001;
            ST_EMERG: light_HW = 3'b001;
            ST_ILL:   light_HW = 3'b100;
        endcase
    end

    assign state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_ctrl_gen2.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_light_ctrl_gen2
// Purpose  : Self-checking bench for traffic_light_ctrl_gen2. A table of
//            per-edge input/expected-state records plus hand-written
//            sequences for tick gating and asynchronous reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_traffic_light_ctrl_gen2;

    localparam logic [2:0] S_HGRN  = 3'd0;
    localparam logic [2:0] S_HYEL  = 3'd1;
    localparam logic [2:0] S_AR1   = 3'd2;
    localparam logic [2:0] S_FGRN  = 3'd3;
    localparam logic [2:0] S_FYEL  = 3'd4;
    localparam logic [2:0] S_AR2   = 3'd5;
    localparam logic [2:0] S_EMERG = 3'd6;

    logic       clk;
    logic       reset;
    logic       tick_en;
    logic       sensor;
    logic       ped_req;
    logic       emergency;
    logic [2:0] light_HW;
    logic [2:0] light_FM;
    logic       ped_walk;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    traffic_light_ctrl_gen2 dut (
        .clk       (clk),
        .reset     (reset),
        .tick_en   (tick_en),
        .sensor    (sensor),
        .ped_req   (ped_req),
        .emergency (emergency),
        .light_HW  (light_HW),
        .light_FM  (light_FM),
        .ped_walk  (ped_walk),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One record = inputs applied for one rising edge and the state expected
    // after it. A do_rst record pulses reset instead.
    typedef struct {
        bit         do_rst;
        bit         t;
        bit         s;
        bit         p;
        bit         e;
        logic [2:0] st;
    } vec_t;

    vec_t vec [0:255];
    int   nv = 0;

    task automatic add(input int n, input bit t, input bit s, input bit p,
                       input bit e, input logic [2:0] st);
        for (int k = 0; k < n; k++) begin
            vec[nv] = '{do_rst: 1'b0, t: t, s: s, p: p, e: e, st: st};
            nv++;
        end
    endtask

    task automatic add_rst();
        vec[nv] = '{do_rst: 1'b1, t: 1'b0, s: 1'b0, p: 1'b0, e: 1'b0, st: S_HGRN};
        nv++;
    endtask

    // Lamp table: {light_HW, light_FM, ped_walk}
    function automatic logic [6:0] lamp(input logic [2:0] s);
        case (s)
            S_HGRN:  lamp = {3'b100, 3'b001, 1'b0};
            S_HYEL:  lamp = {3'b010, 3'b001, 1'b0};
            S_AR1:   lamp = {3'b001, 3'b001, 1'b0};
            S_FGRN:  lamp = {3'b001, 3'b100, 1'b1};
            S_FYEL:  lamp = {3'b001, 3'b010, 1'b0};
            S_AR2:   lamp = {3'b001, 3'b001, 1'b0};
            S_EMERG: lamp = {3'b001, 3'b001, 1'b0};
            default: lamp = {3'b100, 3'b001, 1'b0};
        endcase
    endfunction

    task automatic chk_out(input string nm, input int idx, input logic [2:0] exp_st);
        logic [6:0] exp_l;
        exp_l = lamp(exp_st);
        checks++;
        if (state !== exp_st) begin
            errors++;
            $display("FAIL %s[%0d] state: got %0d expected %0d", nm, idx, state, exp_st);
        end
        checks++;
        if ({light_HW, light_FM, ped_walk} !== exp_l) begin
            errors++;
            $display("FAIL %s[%0d] lamps HW/FM/walk: got %b/%b/%b expected %b/%b/%b",
                     nm, idx, light_HW, light_FM, ped_walk, exp_l[6:4], exp_l[3:1], exp_l[0]);
        end
    endtask

    task automatic chk_val(input string nm, input int idx, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s[%0d]: got %0d expected %0d", nm, idx, act, exp_v);
        end
    endtask

    // Reset pulse starting at a falling edge; outputs are checked before
    // any rising edge has occurred, then reset is held across one edge.
    task automatic do_reset(input string nm);
        @(negedge clk);
        tick_en = 1'b0; sensor = 1'b0; ped_req = 1'b0; emergency = 1'b0;
        reset = 1'b0;
        #1;
        chk_out(nm, 0, S_HGRN);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic step(input bit t, input bit s, input bit p, input bit e);
        tick_en = t; sensor = s; ped_req = p; emergency = e;
        @(negedge clk);
    endtask

    logic [2:0] ph_st  [0:5];
    int         ph_dur [0:5];

    initial begin
        reset = 1'b0; tick_en = 1'b0; sensor = 1'b0; ped_req = 1'b0; emergency = 1'b0;

        // Full cycle, sensor held, 23-cycle period
        add_rst();
        add(4, 1, 1, 0, 0, S_HGRN);
        add(3, 1, 1, 0, 0, S_HYEL);
        add(1, 1, 1, 0, 0, S_AR1);
        add(10, 1, 1, 0, 0, S_FGRN);
        add(3, 1, 1, 0, 0, S_FYEL);
        add(1, 1, 1, 0, 0, S_AR2);
        add(5, 1, 1, 0, 0, S_HGRN);
        add(1, 1, 1, 0, 0, S_HYEL);
        // Single pedestrian pulse right after reset: min green still served,
        // one walk phase, then highway green holds
        add_rst();
        add(1, 1, 0, 1, 0, S_HGRN);
        add(3, 1, 0, 0, 0, S_HGRN);
        add(3, 1, 0, 0, 0, S_HYEL);
        add(1, 1, 0, 0, 0, S_AR1);
        add(10, 1, 0, 0, 0, S_FGRN);
        add(3, 1, 0, 0, 0, S_FYEL);
        add(1, 1, 0, 0, 0, S_AR2);
        add(12, 1, 0, 0, 0, S_HGRN);
        // Emergency at FGRN cycle 4
        add_rst();
        add(4, 1, 1, 0, 0, S_HGRN);
        add(3, 1, 1, 0, 0, S_HYEL);
        add(1, 1, 1, 0, 0, S_AR1);
        add(4, 1, 1, 0, 0, S_FGRN);
        add(3, 1, 1, 0, 1, S_FYEL);
        add(4, 1, 1, 0, 1, S_EMERG);
        add(1, 1, 1, 0, 0, S_AR2);
        add(5, 1, 1, 0, 0, S_HGRN);
        add(1, 1, 1, 0, 0, S_HYEL);
        // Emergency with no ticks: HGRN leaves at once, yellow still timed
        add_rst();
        add(3, 0, 0, 0, 0, S_HGRN);
        add(1, 0, 0, 0, 1, S_HYEL);
        add(2, 0, 0, 0, 1, S_HYEL);
        add(2, 1, 0, 0, 1, S_HYEL);
        add(1, 1, 0, 0, 1, S_EMERG);
        add(2, 0, 0, 0, 1, S_EMERG);
        add(1, 0, 0, 0, 0, S_AR2);
        add(2, 0, 0, 0, 0, S_AR2);
        add(1, 1, 0, 0, 0, S_HGRN);
        // Emergency in AR1 goes straight to EMERG
        add_rst();
        add(4, 1, 1, 0, 0, S_HGRN);
        add(3, 1, 1, 0, 0, S_HYEL);
        add(1, 1, 1, 0, 0, S_AR1);
        add(1, 0, 1, 0, 1, S_EMERG);

        for (int i = 0; i < nv; i++) begin
            if (vec[i].do_rst)
                do_reset("vec_rst");
            else begin
                step(vec[i].t, vec[i].s, vec[i].p, vec[i].e);
                chk_out("vec", i, vec[i].st);
            end
        end

        // Tick gating: tick on every other edge; phases take twice as long
        // and the counter freezes on non-tick edges
        ph_st[0] = S_HGRN; ph_dur[0] = 5;
        ph_st[1] = S_HYEL; ph_dur[1] = 3;
        ph_st[2] = S_AR1;  ph_dur[2] = 1;
        ph_st[3] = S_FGRN; ph_dur[3] = 10;
        ph_st[4] = S_FYEL; ph_dur[4] = 3;
        ph_st[5] = S_AR2;  ph_dur[5] = 1;
        do_reset("gate_rst");
        begin
            int cur;
            int ticks;
            cur = 0;
            ticks = 0;
            for (int i = 0; i < 50; i++) begin
                bit t;
                t = (i % 2 == 0);
                step(t, 1'b1, 1'b0, 1'b0);
                if (t) begin
                    ticks++;
                    if (ticks == ph_dur[cur]) begin
                        cur = (cur + 1) % 6;
                        ticks = 0;
                    end
                end
                chk_out("gate", i, ph_st[cur]);
                chk_val("gate_cnt", i, int'(dut.r_cnt), ticks);
            end
        end

        // Asynchronous reset in the middle of FGRN with a request pending
        do_reset("mid_rst");
        for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk_out("mid_fgrn", 0, S_FGRN);
        chk_val("mid_pending", 0, int'(dut.r_ped_pending), 1);
        #2;
        reset = 1'b0;
        #1;
        chk_out("mid_async", 0, S_HGRN);
        chk_val("mid_pending_clr", 0, int'(dut.r_ped_pending), 0);
        @(negedge clk);
        sensor = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            chk_out("post_rst", i, S_HGRN);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/traffic_light_ctrl_gen2.md
TRAFFIC_LIGHT_CTRL_GEN2 -- requirements
Module: traffic_light_ctrl_gen2

Interface
REQ-001 SHALL have parameter YEL_TICKS, default 3: yellow duration in ticks, both roads (>=1).
REQ-002 SHALL have parameter FM_GRN_TICKS, default 10: farm green duration in ticks (>=1).
REQ-003 SHALL have parameter ALLRED_TICKS, default 1: all-red clearance duration in ticks (>=1).
REQ-004 SHALL have parameter MIN_HW_GRN_TICKS, default 5: minimum highway green in ticks (>=1).
REQ-005 SHALL have parameter CNT_W, default 8: phase counter width; must hold the largest duration minus 1.
REQ-006 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port tick_en  input  1  time-base strobe; each cycle with tick_en=1 is one tick.
REQ-009 SHALL have port sensor  input  1  farm-road vehicle present, level.
REQ-010 SHALL have port ped_req  input  1  pedestrian request; a single-cycle pulse is sufficient.
REQ-011 SHALL have port emergency  input  1  emergency override, level.
REQ-012 SHALL have port light_HW  output  3  highway lamp, one-hot: 100 green, 010 yellow, 001 red.
REQ-013 SHALL have port light_FM  output  3  farm lamp, same encoding as light_HW.
REQ-014 SHALL have port ped_walk  output  1  pedestrian walk indication.
REQ-015 SHALL have port state  output  3  current state code, for debug.

Function
REQ-016 SHALL implement a Moore FSM; outputs decode from the state register only.
REQ-017 State codes and outputs (state: light_HW/light_FM):
- 0 HGRN: 100/001
- 1 HYEL: 010/001
- 2 AR1: 001/001
- 3 FGRN: 001/100
- 4 FYEL: 001/010
- 5 AR2: 001/001
- 6 EMERG: 001/001
REQ-018 SHALL use one phase counter cnt[CNT_W-1:0], cleared to 0 on every state change and held at 0 in EMERG.
REQ-019 In a timed state (HYEL, AR1, FGRN, FYEL, AR2) with duration D:
- on a tick_en=1 edge, cnt SHALL increment;
- the state SHALL expire on the tick_en=1 edge where cnt==D-1.
- With tick_en held at 1, each timed state therefore lasts exactly D cycles.
REQ-020 With tick_en=0, cnt and state SHALL hold; only emergency and reset act without a tick.
REQ-021 Normal sequence on expiry: HYEL->AR1->FGRN->FYEL->AR2->HGRN.
REQ-022 In HGRN, cnt SHALL increment on ticks and saturate at MIN_HW_GRN_TICKS-1.
REQ-023 HGRN->HYEL SHALL occur on a tick_en=1 edge when cnt==MIN_HW_GRN_TICKS-1 and (sensor or ped_pending) is true; otherwise HGRN holds indefinitely.
REQ-024 The internal ped_pending flag SHALL be set by ped_req=1 on any edge and cleared on entry to FGRN; when set and clear fall on the same edge, clear wins.
REQ-025 ped_walk SHALL be 1 only in FGRN.
REQ-026 emergency=1 sampled on any edge SHALL have these effects:
- HGRN->HYEL immediately;
- FGRN->FYEL immediately;
- HYEL/FYEL SHALL complete their full yellow and then go to EMERG;
- AR1/AR2 SHALL go to EMERG immediately.
Emergency takes priority over sensor and ped_pending.
REQ-027 EMERG SHALL hold while emergency=1; when emergency=0 is sampled, EMERG SHALL go to AR2, then AR2 SHALL run its full duration and go to HGRN.
REQ-028 Illegal state code 7 SHALL decode to 100/001 with ped_walk=0 and go to HGRN on the next edge.

Reset
REQ-029 reset=0 SHALL force, asynchronously and at any time:
- state=HGRN, cnt=0, ped_pending=0;
- light_HW=100, light_FM=001, ped_walk=0.
REQ-030 After reset release, HGRN SHALL serve the full minimum green before any request is honoured.

Verification
REQ-031 Full cycle: tick_en=1, sensor=1, defaults. Phases SHALL be HGRN 5, HYEL 3, AR1 1, FGRN 10, FYEL 3, AR2 1 cycles, repeating with a 23-cycle period.
REQ-032 Pedestrian: sensor=0, ped_req pulsed once. SHALL give one full cycle with ped_walk=1 for exactly 10 cycles, then stay in HGRN.
REQ-033 Tick gating: tick_en toggled 1/0 each cycle, sensor=1. Every phase SHALL take twice its cycle count, and cnt SHALL freeze on tick_en=0 cycles.
REQ-034 Emergency: emergency=1 at FGRN cycle 4. SHALL give FYEL 3 cycles, then EMERG held. On release: AR2 1 cycle, then HGRN for at least 5 cycles.
REQ-035 Reset mid-FGRN with ped_pending set: outputs SHALL go to 100/001/0 without a clock edge, state=0, and no cycle shall start while sensor=0.
